data_ram_arbiter: RTL and testbench

// - Shares the single-port data RAM between the CPU load/store port and a read-only video/DMA port.
// - Sits between the CPU datapath (ALU result as address, R3 as store data) and the RAM.
// - The CPU holds its stage while cpu_req=1 and cpu_ack=0.
// - Serialises accesses with a 3-state FSM; video has priority, with a starvation guard for the CPU.

---
 rtl/data_ram_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_ram_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_ram_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store port and a read-only video port.
// Optional build macro RAM_ARB_RR_EN selects round-robin instead of video priority with a CPU starvation guard.
module data_ram_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_ack,
    input  logic          i_vid_req,
    input  logic [AW-1:0] i_vid_addr,
    output logic [DW-1:0] o_vid_rdata,
    output logic          o_vid_ack,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    localparam int WCW = $clog2(CPU_MAX_WAIT + 1);
    localparam logic [WCW-1:0] MAX_WAIT = WCW'(CPU_MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_win_cpu;
    logic            r_store;
    logic            r_ram_we;
    logic [AW-1:0]   r_ram_addr;
    logic [DW-1:0]   r_ram_wdata;
    logic            r_cpu_ack;
    logic            r_vid_ack;
    logic [DW-1:0]   r_cpu_rdata;
    logic [DW-1:0]   r_vid_rdata;
    logic [WCW-1:0]  r_wait_cnt;
    logic            w_cpu_wins;
`ifdef RAM_ARB_RR_EN
    logic            r_rr_last;   // 1 = last grant went to the CPU
`endif

    // Winner selection for the current IDLE cycle.
    always_comb begin
        w_cpu_wins = 1'b0;
`ifdef RAM_ARB_RR_EN
        if (i_cpu_req && i_vid_req) begin
            w_cpu_wins = ~r_rr_last;
        end else begin
            w_cpu_wins = i_cpu_req;
        end
`else
        if (i_cpu_req && (!i_vid_req || (r_wait_cnt == MAX_WAIT))) begin
            w_cpu_wins = 1'b1;
        end else begin
            w_cpu_wins = 1'b0;
        end
`endif
    end

    // Access sequencer: IDLE latches the winner, ACCESS drives the RAM, RESP acks and captures read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_win_cpu   <= 1'b0;
            r_store     <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= {AW{1'b0}};
            r_ram_wdata <= {DW{1'b0}};
            r_cpu_ack   <= 1'b0;
            r_vid_ack   <= 1'b0;
            r_cpu_rdata <= {DW{1'b0}};
            r_vid_rdata <= {DW{1'b0}};
            r_wait_cnt  <= {WCW{1'b0}};
`ifdef RAM_ARB_RR_EN
            r_rr_last   <= 1'b1;
`endif
        end else begin
            r_cpu_ack <= 1'b0;
            r_vid_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_cpu_req || i_vid_req) begin
                        r_win_cpu   <= w_cpu_wins;
                        r_store     <= w_cpu_wins & i_cpu_we;
                        r_ram_we    <= w_cpu_wins & i_cpu_we;
                        r_ram_addr  <= w_cpu_wins ? i_cpu_addr : i_vid_addr;
                        r_ram_wdata <= w_cpu_wins ? i_cpu_wdata : r_ram_wdata;
`ifdef RAM_ARB_RR_EN
                        r_rr_last   <= w_cpu_wins;
                        r_wait_cnt  <= {WCW{1'b0}};
`else
                        if (w_cpu_wins) begin
                            r_wait_cnt <= {WCW{1'b0}};
                        end else if (i_cpu_req && (r_wait_cnt != MAX_WAIT)) begin
                            r_wait_cnt <= r_wait_cnt + WCW'(1);
                        end else begin
                            r_wait_cnt <= r_wait_cnt;
                        end
`endif
                        r_state     <= S_ACCESS;
                    end else begin
                        r_ram_we <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    r_ram_we  <= 1'b0;
                    r_cpu_ack <= r_win_cpu;
                    r_vid_ack <= ~r_win_cpu;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (r_win_cpu && !r_store) begin
                        r_cpu_rdata <= i_ram_rdata;
                    end else if (!r_win_cpu) begin
                        r_vid_rdata <= i_ram_rdata;
                    end else begin
                        r_cpu_rdata <= r_cpu_rdata;
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ram_we <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // RAM data arrives in RESP, so the winner sees it directly while its ack is high.
    assign o_cpu_rdata = (r_state == S_RESP && r_win_cpu && !r_store) ? i_ram_rdata : r_cpu_rdata;
    assign o_vid_rdata = (r_state == S_RESP && !r_win_cpu) ? i_ram_rdata : r_vid_rdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_vid_ack   = r_vid_ack;
    assign o_ram_we    = r_ram_we;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed scoreboard bench for data_ram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_data_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, vid_req;
    logic [31:0] cpu_addr, cpu_wdata, vid_addr;
    logic [31:0] cpu_rdata, vid_rdata, ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'd0;
    logic        cpu_ack, vid_ack, ram_we;
    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        bit          is_cpu;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_ack(cpu_ack),
        .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_rdata(vid_rdata),
        .o_vid_ack(vid_ack), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
        ram_rdata <= mem[ram_addr[7:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_cpu, input logic [31:0] data);
        exp_t e;
        e.is_cpu = is_cpu;
        e.data   = data;
        sb.push_back(e);
    endtask

    // Advance one cycle and score any ack against the queue head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (cpu_ack || vid_ack) begin
            chk("single_ack", 32'(cpu_ack & vid_ack), 32'd0);
            chk("ack_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_port_cpu", 32'(cpu_ack), 32'(e.is_cpu));
                chk("rdata", e.is_cpu ? cpu_rdata : vid_rdata, e.data);
            end
        end
    endtask

    initial begin
        int  wexp;
        bit  exp_c;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[8] = 32'hCAFE_F00D;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
        vid_req = 1'b0; vid_addr = 32'd0;
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(dut.r_state), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wdata", ram_wdata, 32'd0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
        chk("rst_vid_ack", 32'(vid_ack), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_vid_rdata", vid_rdata, 32'd0);
        chk("rst_wait_cnt", 32'(dut.r_wait_cnt), 32'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        // CPU store 0x10; cpu_rdata must keep its old value (0) on the ack
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF;
        push(1'b1, 32'h0);
        tick();
        chk("st_access_state", 32'(dut.r_state), 32'd1);
        chk("st_access_we", 32'(ram_we), 32'd1);
        chk("st_access_addr", ram_addr, 32'h10);
        chk("st_access_wdata", ram_wdata, 32'hDEAD_BEEF);
        chk("st_no_early_ack", 32'(cpu_ack), 32'd0);
        tick();
        chk("st_resp_we", 32'(ram_we), 32'd0);
        chk("st_ack_n2", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        tick();
        chk("st_idle_ack", 32'(cpu_ack | vid_ack), 32'd0);

        // CPU load 0x10
        cpu_req = 1'b1; cpu_we = 1'b0;
        push(1'b1, 32'hDEAD_BEEF);
        tick();
        chk("ld_access_we", 32'(ram_we), 32'd0);
        tick();
        chk("ld_ack_n2", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        tick();
        chk("ld_rdata_held", cpu_rdata, 32'hDEAD_BEEF);
        chk("ld_vid_rdata_untouched", vid_rdata, 32'd0);

        // Video read 0x20 while a CPU store is pending
        vid_req = 1'b1; vid_addr = 32'h20;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h1111_2222;
        push(1'b0, 32'hCAFE_F00D);
        push(1'b1, 32'hDEAD_BEEF);
        tick();
        chk("vid_access_we", 32'(ram_we), 32'd0);
        chk("vid_access_addr", ram_addr, 32'h20);
`ifdef RAM_ARB_RR_EN
        chk("vid_wait_cnt", 32'(dut.r_wait_cnt), 32'd0);
`else
        chk("vid_wait_cnt", 32'(dut.r_wait_cnt), 32'd1);
`endif
        tick();
        chk("vid_ack_n2", 32'(vid_ack), 32'd1);
        vid_req = 1'b0;
        tick();
        tick();
        chk("pend_st_we", 32'(ram_we), 32'd1);
        chk("pend_st_addr", ram_addr, 32'h30);
        chk("pend_wait_cnt_clr", 32'(dut.r_wait_cnt), 32'd0);
        tick();
        cpu_req = 1'b0;
        tick();
        chk("vid_rdata_held", vid_rdata, 32'hCAFE_F00D);

        // Both requesters held high: check grant order and wait_cnt per grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        vid_req = 1'b1; vid_addr = 32'h20;
        wexp = 0;
        for (int g = 0; g < 10; g++) begin
`ifdef RAM_ARB_RR_EN
            exp_c = (g % 2 == 1);
            wexp  = 0;
`else
            exp_c = (g % 5 == 4);
            wexp  = exp_c ? 0 : ((wexp < 4) ? wexp + 1 : 4);
`endif
            push(exp_c, exp_c ? 32'hDEAD_BEEF : 32'hCAFE_F00D);
            tick();
            chk("cont_wait_cnt", 32'(dut.r_wait_cnt), 32'(wexp));
            chk("cont_addr", ram_addr, exp_c ? 32'h10 : 32'h20);
            tick();
            if (g == 9) begin
                cpu_req = 1'b0; vid_req = 1'b0;
            end
            tick();
        end
        chk("cont_sb_drained", 32'(sb.size()), 32'd0);

        // Reset during ACCESS of a CPU store
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h0000_0055;
        tick();
        chk("abort_pre_we", 32'(ram_we), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_we", 32'(ram_we), 32'd0);
        chk("abort_state", 32'(dut.r_state), 32'd0);
        chk("abort_rdata_rst", cpu_rdata, 32'd0);
        tick();
        chk("abort_no_ack", 32'(cpu_ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(1'b1, 32'd0);
        tick();
        chk("post_rst_we", 32'(ram_we), 32'd1);
        chk("post_rst_addr", ram_addr, 32'h40);
        tick();
        chk("post_rst_ack_n2", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        tick();
        chk("post_rst_mem", mem[16], 32'h0000_0055);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
